// File: rtl/integer_assignment_commit.sv
// rtl/integer_assignment_commit.sv - sweep controller and assignment store for the integer proposal path
// Issues one proposal per variable, applies a Metropolis accept/reject and commits accepted values.
module integer_assignment_commit #(
   parameter int NUM_VARS    = 4,
   parameter int VAR_WIDTH   = 8,
   parameter int INDEX_WIDTH = 2,
   parameter int ITER_WIDTH  = 16,
   parameter int TIMEOUT     = 255
) (
   input  logic                          in_clk,
   input  logic                          in_reset,
   input  logic                          in_load,
   input  logic [INDEX_WIDTH-1:0]        in_load_index,
   input  logic [VAR_WIDTH-1:0]          in_load_value,
   input  logic                          in_start,
   input  logic [ITER_WIDTH-1:0]         in_iterations,
   input  logic                          in_proposal_valid,
   input  logic [VAR_WIDTH-1:0]          in_assignment_new,
   input  logic [15:0]                   in_random,
   input  logic [15:0]                   in_accept_prob,
   output logic [INDEX_WIDTH-1:0]        out_variable_index,
   output logic                          out_enable,
   output logic [NUM_VARS*VAR_WIDTH-1:0] out_assignments_old,
   output logic                          out_busy,
   output logic                          out_done,
   output logic [ITER_WIDTH-1:0]         out_accept_count,
   output logic                          out_timeout_error
);

   localparam int WAIT_WIDTH = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT, S_COMMIT, S_NEXT, S_DONE
   } state_t;

   state_t                  r_state, w_state_next;
   logic [VAR_WIDTH-1:0]    r_store [NUM_VARS];
   logic [INDEX_WIDTH-1:0]  r_index;
   logic [ITER_WIDTH-1:0]   r_iters;
   logic [ITER_WIDTH-1:0]   r_sweep;
   logic [ITER_WIDTH-1:0]   r_accept_count;
   logic [WAIT_WIDTH-1:0]   r_wait_cnt;
   logic [VAR_WIDTH-1:0]    r_new_value;
   logic                    r_accept;
   logic                    r_timeout_error;
   logic                    w_accept;
   logic                    w_last_var;
   logic                    w_wait_expired;
   logic [ITER_WIDTH-1:0]   w_sweep_inc;

   // 0xFFFF is special-cased so "always accept" holds even for random == 0xFFFF
   assign w_accept       = (in_accept_prob == 16'hFFFF) || (in_random < in_accept_prob);
   assign w_last_var     = (r_index == INDEX_WIDTH'(NUM_VARS - 1));
   assign w_wait_expired = (r_wait_cnt == WAIT_WIDTH'(TIMEOUT - 1));
   assign w_sweep_inc    = r_sweep + ITER_WIDTH'(1);

   always_ff @(posedge in_clk or posedge in_reset) begin
      if (in_reset) r_state <= S_IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      out_enable   = 1'b0;
      out_done     = 1'b0;
      case (r_state)
         S_IDLE:   if (in_start) w_state_next = (in_iterations == '0) ? S_DONE : S_ISSUE;
         S_ISSUE:  begin
            out_enable   = 1'b1;
            w_state_next = S_WAIT;
         end
         S_WAIT:   begin
            if (in_proposal_valid)   w_state_next = S_COMMIT;
            else if (w_wait_expired) w_state_next = S_NEXT;
         end
         S_COMMIT: w_state_next = S_NEXT;
         S_NEXT:   w_state_next = (w_last_var && (w_sweep_inc == r_iters)) ? S_DONE : S_ISSUE;
         S_DONE:   begin
            out_done     = 1'b1;
            w_state_next = S_IDLE;
         end
         default:  w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge in_clk or posedge in_reset) begin
      if (in_reset) begin
         for (int i = 0; i < NUM_VARS; i++) r_store[i] <= '0;
         r_index         <= '0;
         r_iters         <= '0;
         r_sweep         <= '0;
         r_accept_count  <= '0;
         r_wait_cnt      <= '0;
         r_new_value     <= '0;
         r_accept        <= 1'b0;
         r_timeout_error <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // Load lands on the same edge as start, so the first request sees it
               if (in_load && (int'(in_load_index) < NUM_VARS)) r_store[in_load_index] <= in_load_value;
               if (in_start) begin
                  r_iters         <= in_iterations;
                  r_sweep         <= '0;
                  r_index         <= '0;
                  r_accept_count  <= '0;
                  r_timeout_error <= 1'b0;
               end
            end
            S_ISSUE: r_wait_cnt <= '0;
            S_WAIT: begin
               r_wait_cnt <= r_wait_cnt + WAIT_WIDTH'(1);
               if (in_proposal_valid) begin
                  r_new_value <= in_assignment_new;
                  r_accept    <= w_accept;
               end else if (w_wait_expired) begin
                  r_timeout_error <= 1'b1;
               end
            end
            S_COMMIT: begin
               if (r_accept) begin
                  r_store[r_index] <= r_new_value;
                  if (r_accept_count != '1) r_accept_count <= r_accept_count + ITER_WIDTH'(1);
               end
            end
            S_NEXT: begin
               if (w_last_var) begin
                  r_index <= '0;
                  r_sweep <= w_sweep_inc;
               end else begin
                  r_index <= r_index + INDEX_WIDTH'(1);
               end
            end
            default: ;
         endcase
      end
   end

   genvar g;
   generate
      for (g = 0; g < NUM_VARS; g++) begin : g_flatten
         assign out_assignments_old[g*VAR_WIDTH +: VAR_WIDTH] = r_store[g];
      end
   endgenerate

   assign out_variable_index = r_index;
   assign out_busy           = (r_state != S_IDLE);
   assign out_accept_count   = r_accept_count;
   assign out_timeout_error  = r_timeout_error;

endmodule

// File: tb/tb_integer_assignment_commit.sv
// tb/tb_integer_assignment_commit.sv - directed self-checking bench for integer_assignment_commit
// Vector table for accept/reject sweeps plus hand sequences for reset, zero-iteration, timeout and multi-sweep runs.
module tb_integer_assignment_commit;

   localparam int NV = 4;
   localparam int VW = 8;
   localparam int IW = 2;
   localparam int TW = 16;
   localparam int TO = 255;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_load = 1'b0;
   logic [IW-1:0]     in_load_index = '0;
   logic [VW-1:0]     in_load_value = '0;
   logic              in_start = 1'b0;
   logic [TW-1:0]     in_iterations = '0;
   logic              in_proposal_valid = 1'b0;
   logic [VW-1:0]     in_assignment_new = '0;
   logic [15:0]       in_random = '0;
   logic [15:0]       in_accept_prob = '0;
   logic [IW-1:0]     out_variable_index;
   logic              out_enable;
   logic [NV*VW-1:0]  out_assignments_old;
   logic              out_busy;
   logic              out_done;
   logic [TW-1:0]     out_accept_count;
   logic              out_timeout_error;

   always #5 clk = ~clk;

   integer_assignment_commit #(
      .NUM_VARS(NV), .VAR_WIDTH(VW), .INDEX_WIDTH(IW), .ITER_WIDTH(TW), .TIMEOUT(TO)
   ) dut (
      .in_clk(clk),
      .in_reset(rst),
      .in_load(in_load),
      .in_load_index(in_load_index),
      .in_load_value(in_load_value),
      .in_start(in_start),
      .in_iterations(in_iterations),
      .in_proposal_valid(in_proposal_valid),
      .in_assignment_new(in_assignment_new),
      .in_random(in_random),
      .in_accept_prob(in_accept_prob),
      .out_variable_index(out_variable_index),
      .out_enable(out_enable),
      .out_assignments_old(out_assignments_old),
      .out_busy(out_busy),
      .out_done(out_done),
      .out_accept_count(out_accept_count),
      .out_timeout_error(out_timeout_error)
   );

   typedef struct {
      logic [31:0] load;
      logic [15:0] prob;
      logic [15:0] rnd;
      logic [31:0] exp_store;
      logic [15:0] exp_cnt;
   } vec_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_en;
   int          n_done;
   int          done_cyc;
   int          silent_idx = -1;
   int          en_idx[$];
   int          en_time[$];
   logic [31:0] first_old;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic load_all(input logic [31:0] vals);
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         in_load       = 1'b1;
         in_load_index = IW'(i);
         in_load_value = vals[i*VW +: VW];
      end
      @(negedge clk);
      in_load = 1'b0;
   endtask

   // Acts as the proposer: answers each enable one cycle later with index+10 unless silenced
   task automatic run(input int budget, input int inject_at);
      bit            pend;
      bit            seen_done;
      logic [IW-1:0] pidx;
      pend = 0; seen_done = 0; pidx = '0;
      n_en = 0; n_done = 0; done_cyc = -1;
      en_idx.delete(); en_time.delete();
      for (int cyc = 0; cyc < budget; cyc++) begin
         @(negedge clk);
         in_proposal_valid = 1'b0;
         in_load           = 1'b0;
         in_start          = 1'b0;
         if (pend) begin
            if (int'(pidx) != silent_idx) begin
               in_proposal_valid = 1'b1;
               in_assignment_new = VW'(pidx) + 8'd10;
            end
            pend = 0;
         end
         if (out_enable) begin
            if (n_en == 0) first_old = out_assignments_old;
            en_idx.push_back(int'(out_variable_index));
            en_time.push_back(cyc);
            pidx = out_variable_index;
            pend = 1;
            n_en++;
            if (n_en == inject_at) begin
               in_load       = 1'b1;
               in_load_index = '0;
               in_load_value = 8'd99;
               in_start      = 1'b1;
               in_iterations = 16'd1;
            end
         end
         if (out_done) begin
            if (n_done == 0) done_cyc = cyc;
            n_done++;
            seen_done = 1;
         end else if (seen_done) begin
            break;
         end
      end
      check("run_completed", 64'(seen_done), 64'd1);
   endtask

   vec_t vecs[7];

   initial begin
      vecs[0] = '{32'h0007FE03, 16'hFFFF, 16'h0000, 32'h0D0C0B0A, 16'd4};
      vecs[1] = '{32'h04030201, 16'h8000, 16'h7FFF, 32'h0D0C0B0A, 16'd4};
      vecs[2] = '{32'h04030201, 16'h8000, 16'h8000, 32'h04030201, 16'd0};
      vecs[3] = '{32'h057F80FF, 16'h0000, 16'h0000, 32'h057F80FF, 16'd0};
      vecs[4] = '{32'h00000000, 16'hFFFF, 16'hFFFF, 32'h0D0C0B0A, 16'd4};
      vecs[5] = '{32'h11223344, 16'h0001, 16'h0000, 32'h0D0C0B0A, 16'd4};
      vecs[6] = '{32'h11223344, 16'h0001, 16'h0001, 32'h11223344, 16'd0};

      repeat (2) @(negedge clk);
      check("rst_busy", 64'(out_busy), 64'd0);
      check("rst_enable", 64'(out_enable), 64'd0);
      check("rst_done", 64'(out_done), 64'd0);
      check("rst_store", 64'(out_assignments_old), 64'd0);
      check("rst_count", 64'(out_accept_count), 64'd0);
      check("rst_timeout", 64'(out_timeout_error), 64'd0);
      rst = 1'b0;

      foreach (vecs[v]) begin
         in_random      = vecs[v].rnd;
         in_accept_prob = vecs[v].prob;
         load_all(vecs[v].load);
         in_start      = 1'b1;
         in_iterations = 16'd1;
         run(100, -1);
         check($sformatf("vec%0d_store", v), 64'(out_assignments_old), 64'(vecs[v].exp_store));
         check($sformatf("vec%0d_count", v), 64'(out_accept_count), 64'(vecs[v].exp_cnt));
         check($sformatf("vec%0d_enables", v), 64'(n_en), 64'd4);
         check($sformatf("vec%0d_dones", v), 64'(n_done), 64'd1);
         if (v == 0) check("period_4", 64'(en_time[1] - en_time[0]), 64'd4);
      end

      // Zero iterations: done the cycle after start, no proposals
      in_start      = 1'b1;
      in_iterations = 16'd0;
      run(10, -1);
      check("zero_enables", 64'(n_en), 64'd0);
      check("zero_done_cyc", 64'(done_cyc), 64'd0);
      check("zero_dones", 64'(n_done), 64'd1);
      check("zero_store", 64'(out_assignments_old), 64'h11223344);
      check("zero_busy", 64'(out_busy), 64'd0);

      // Proposer silent on variable 1
      silent_idx     = 1;
      in_accept_prob = 16'hFFFF;
      load_all(32'h04030201);
      in_start      = 1'b1;
      in_iterations = 16'd1;
      run(2000, -1);
      check("to_enables", 64'(n_en), 64'd4);
      check("to_var2_index", 64'(en_idx[2]), 64'd2);
      check("to_gap", 64'(en_time[2] - en_time[1]), 64'(TO + 2));
      check("to_flag", 64'(out_timeout_error), 64'd1);
      check("to_count", 64'(out_accept_count), 64'd3);
      check("to_store", 64'(out_assignments_old), 64'h0D0C020A);
      silent_idx = -1;

      // Three sweeps, all rejected, load/start injected mid-run
      in_accept_prob = 16'h0000;
      in_random      = 16'h0000;
      load_all(32'h04030201);
      in_start      = 1'b1;
      in_iterations = 16'd3;
      run(300, 5);
      check("multi_enables", 64'(n_en), 64'd12);
      for (int k = 0; k < 12; k++) check($sformatf("multi_idx%0d", k), 64'(en_idx[k]), 64'(k % NV));
      check("multi_store", 64'(out_assignments_old), 64'h04030201);
      check("multi_timeout_cleared", 64'(out_timeout_error), 64'd0);
      check("multi_dones", 64'(n_done), 64'd1);

      // Load and start in the same cycle
      in_accept_prob = 16'hFFFF;
      @(negedge clk);
      in_load       = 1'b1;
      in_load_index = 2'd0;
      in_load_value = 8'h37;
      in_start      = 1'b1;
      in_iterations = 16'd1;
      run(100, -1);
      check("ls_first_old", 64'(first_old), 64'h04030237);
      check("ls_store", 64'(out_assignments_old), 64'h0D0C0B0A);

      // Reset while waiting on a proposal
      silent_idx = 0;
      @(negedge clk);
      in_start      = 1'b1;
      in_iterations = 16'd1;
      @(negedge clk);
      in_start = 1'b0;
      check("mid_enable", 64'(out_enable), 64'd1);
      @(negedge clk);
      check("mid_in_wait", 64'(out_busy), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_busy", 64'(out_busy), 64'd0);
      check("mid_store", 64'(out_assignments_old), 64'd0);
      rst = 1'b0;
      n_done = 0;
      repeat (20) begin
         @(negedge clk);
         if (out_done) n_done++;
      end
      check("mid_no_done", 64'(n_done), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
